// File: rtl/op_arith_pipe.sv
// Two-stage valid/ready operand pipeline: ADD/SUB/ACC/CLR arithmetic plus slice, concat and constant.
// OP_ARITH_PIPE_SAT_EN: when defined, the ACC sum saturates to all ones instead of wrapping.
module op_arith_pipe #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CUT_W     = 10,
  parameter int unsigned CONST_VAL = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic [WIDTH-1:0]     op3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       res1,
  output logic [WIDTH:0]       res2,
  output logic [CUT_W-1:0]     cut,
  output logic [2*WIDTH-1:0]   comb,
  output logic [WIDTH-1:0]     const_o,
  output logic [WIDTH:0]       acc_o
);

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_ACC = 2'd2;

  logic             s1_valid;
  logic [1:0]       s1_mode;
  logic [WIDTH-1:0] s1_op1;
  logic [WIDTH-1:0] s1_op2;
  logic [WIDTH-1:0] s1_op3;
  logic             s2_valid;
  logic [WIDTH:0]   acc;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic [WIDTH:0]   res1_d;
  logic [WIDTH:0]   res2_d;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH:0]   acc_res;

  // Each stage may advance when it is empty or the stage ahead is draining.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign acc_o     = acc;
  assign const_o   = WIDTH'(CONST_VAL);

`ifdef OP_ARITH_PIPE_SAT_EN
  logic [WIDTH+1:0] acc_sum;
  assign acc_sum = {1'b0, acc} + {2'b00, s1_op1};
  assign acc_res = acc_sum[WIDTH+1] ? {(WIDTH+1){1'b1}} : acc_sum[WIDTH:0];
`else
  assign acc_res = acc + {1'b0, s1_op1};
`endif

  // Results for the transaction sitting in S1.
  always_comb begin
    res1_d = '0;
    res2_d = '0;
    acc_d  = acc;
    case (s1_mode)
      MODE_ADD: begin
        res1_d = {1'b0, s1_op1} + {1'b0, s1_op2};
        res2_d = {1'b0, s1_op2} + {1'b0, s1_op3};
      end
      MODE_SUB: begin
        res1_d = {1'b0, s1_op1} - {1'b0, s1_op2};
        res2_d = {1'b0, s1_op2} - {1'b0, s1_op3};
      end
      MODE_ACC: begin
        res1_d = acc_res;
        res2_d = acc;
        acc_d  = acc_res;
      end
      default: begin
        res1_d = '0;
        res2_d = acc;
        acc_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      s1_op3   <= '0;
      s2_valid <= 1'b0;
      res1     <= '0;
      res2     <= '0;
      cut      <= '0;
      comb     <= '0;
      acc      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_mode <= mode;
          s1_op1  <= op1;
          s1_op2  <= op2;
          s1_op3  <= op3;
        end
      end
      // acc moves only together with its transaction entering S2.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          res1 <= res1_d;
          res2 <= res2_d;
          cut  <= s1_op1[CUT_W-1:0];
          comb <= {s1_op1, s1_op2};
          acc  <= acc_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_op_arith_pipe.sv
// Bench for op_arith_pipe: directed steps plus random traffic against a queue-based reference model.
module tb_op_arith_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 10;
  localparam longint unsigned MAXV = (64'd1 << (W + 1)) - 64'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      mode;
  logic [W-1:0]    op1, op2, op3;
  logic            out_valid;
  logic            out_ready;
  logic [W:0]      res1, res2, acc_o;
  logic [CW-1:0]   cut;
  logic [2*W-1:0]  comb;
  logic [W-1:0]    const_o;

  op_arith_pipe #(.WIDTH(W), .CUT_W(CW), .CONST_VAL(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .op1(op1), .op2(op2), .op3(op3), .out_valid(out_valid), .out_ready(out_ready),
    .res1(res1), .res2(res2), .cut(cut), .comb(comb), .const_o(const_o), .acc_o(acc_o)
  );

  logic        in_v8, in_r8, out_v8, out_r8;
  logic [1:0]  mode8;
  logic [7:0]  a8, b8, c8, const8;
  logic [8:0]  res1_8, res2_8, acc8;
  logic [3:0]  cut8;
  logic [15:0] comb8;

  op_arith_pipe #(.WIDTH(8), .CUT_W(4), .CONST_VAL(32)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_v8), .in_ready(in_r8), .mode(mode8),
    .op1(a8), .op2(b8), .op3(c8), .out_valid(out_v8), .out_ready(out_r8),
    .res1(res1_8), .res2(res2_8), .cut(cut8), .comb(comb8), .const_o(const8), .acc_o(acc8)
  );

  typedef struct {
    logic [W:0]     r1;
    logic [W:0]     r2;
    logic [CW-1:0]  cut;
    logic [2*W-1:0] comb;
    int             k;
  } exp_t;

  exp_t            q[$];
  longint unsigned m_acc = 0;
  int              edge_cnt = 0;
  int              n_cmp = 0;
  int              n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result for one transaction, in transaction order; updates the model accumulator.
  function automatic exp_t model(input logic [1:0] md, input logic [W-1:0] a, b, c);
    exp_t e;
    longint unsigned x = 64'(a);
    longint unsigned y = 64'(b);
    longint unsigned z = 64'(c);
    longint unsigned s;
    e.cut  = a[CW-1:0];
    e.comb = {a, b};
    e.k    = 0;
    case (md)
      2'd0: begin e.r1 = (W+1)'(x + y); e.r2 = (W+1)'(y + z); end
      2'd1: begin e.r1 = (W+1)'(x - y); e.r2 = (W+1)'(y - z); end
      2'd2: begin
        s = m_acc + x;
`ifdef OP_ARITH_PIPE_SAT_EN
        if (s > MAXV) s = MAXV;
`else
        s = s & MAXV;
`endif
        e.r2  = (W+1)'(m_acc);
        e.r1  = (W+1)'(s);
        m_acc = s;
      end
      default: begin e.r1 = '0; e.r2 = (W+1)'(m_acc); m_acc = 0; end
    endcase
    return e;
  endfunction

  // One clock: called at a falling edge with inputs already set; returns to the next falling edge.
  task automatic cycle(output bit accepted);
    bit   exp_ir, exp_ov;
    exp_t e;
    #1;
    exp_ir = !rst && (q.size() < 2 || out_ready);
    exp_ov = q.size() > 0 && q[0].k < edge_cnt;
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      chk("res1", 64'(res1), 64'(q[0].r1));
      chk("res2", 64'(res2), 64'(q[0].r2));
      chk("cut", 64'(cut), 64'(q[0].cut));
      chk("comb", comb, q[0].comb);
    end
    accepted = in_valid && exp_ir;
    @(posedge clk);
    edge_cnt++;
    if (rst) begin
      q.delete();
      m_acc = 0;
      accepted = 1'b0;
    end else begin
      if (exp_ov && out_ready) void'(q.pop_front());
      if (accepted) begin
        e   = model(mode, op1, op2, op3);
        e.k = edge_cnt;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit         got;
    int         sent;
    int         got8;
    logic [8:0] r8 [3];
    logic [8:0] e8 [3];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'd0;
    op1 = '0; op2 = '0; op3 = '0;
    in_v8 = 1'b0; out_r8 = 1'b1; mode8 = 2'd0; a8 = '0; b8 = '0; c8 = '0;

    // Reset held three cycles, then released with no traffic.
    repeat (2) @(negedge clk);
    cycle(got);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_res1", 64'(res1), 64'(0));
    chk("rst_res2", 64'(res2), 64'(0));
    chk("rst_acc", 64'(acc_o), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("const_rst", 64'(const_o), 64'd32);
    rst = 1'b0;
    cycle(got);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // ADD with carry out.
    in_valid = 1'b1; mode = 2'd0; op1 = 32'hFFFF_FFFF; op2 = 32'd1; op3 = 32'd2;
    cycle(got);
    in_valid = 1'b0;
    cycle(got);
    chk("add_res1", 64'(res1), 64'h1_0000_0000);
    chk("add_res2", 64'(res2), 64'd3);
    chk("add_cut", 64'(cut), 64'h3FF);
    chk("add_comb", comb, 64'hFFFF_FFFF_0000_0001);
    cycle(got);

    // SUB with borrow.
    in_valid = 1'b1; mode = 2'd1; op1 = 32'd5; op2 = 32'd7; op3 = 32'd7;
    cycle(got);
    in_valid = 1'b0;
    cycle(got);
    chk("sub_res1", 64'(res1), 64'h1_FFFF_FFFE);
    chk("sub_res2", 64'(res2), 64'd0);
    cycle(got);

    // ACC streaming followed by CLR.
    in_valid = 1'b1; mode = 2'd2; op1 = 32'd10;
    cycle(got);
    op1 = 32'd20;
    cycle(got);
    chk("acc_res1_a", 64'(res1), 64'd10);
    op1 = 32'd30;
    cycle(got);
    chk("acc_res1_b", 64'(res1), 64'd30);
    mode = 2'd3;
    cycle(got);
    chk("acc_res1_c", 64'(res1), 64'd60);
    in_valid = 1'b0;
    cycle(got);
    chk("clr_res1", 64'(res1), 64'd0);
    chk("clr_res2", 64'(res2), 64'd60);
    cycle(got);
    chk("clr_acc", 64'(acc_o), 64'd0);

    // Backpressure: four ADDs against a five-cycle stall.
    out_ready = 1'b0; sent = 0; mode = 2'd0;
    op1 = $urandom; op2 = $urandom; op3 = $urandom;
    for (int i = 0; i < 30 && (sent < 4 || q.size() > 0); i++) begin
      if (i == 5) out_ready = 1'b1;
      in_valid = (sent < 4);
      cycle(got);
      if (got) begin
        sent++;
        op1 = $urandom; op2 = $urandom; op3 = $urandom;
      end
      if (i == 3) chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    chk("bp_sent", 64'(sent), 64'd4);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Reset with both stages full, acc already updated.
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'd2; op1 = 32'd7;
    cycle(got);
    mode = 2'd0; op1 = 32'd1; op2 = 32'd2;
    cycle(got);
    chk("mid_acc_before", 64'(acc_o), 64'd7);
    rst = 1'b1; in_valid = 1'b0;
    cycle(got);
    rst = 1'b0;
    chk("mid_out_valid", 64'(out_valid), 64'(0));
    chk("mid_acc", 64'(acc_o), 64'd0);
    out_ready = 1'b1; in_valid = 1'b1; mode = 2'd0; op1 = 32'd3; op2 = 32'd4; op3 = 32'd5;
    cycle(got);
    in_valid = 1'b0;
    cycle(got);
    chk("mid_first_res1", 64'(res1), 64'd7);
    chk("mid_first_res2", 64'(res2), 64'd9);
    cycle(got);

    // Random traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 2'($urandom_range(0, 3));
      op1 = $urandom; op2 = $urandom; op3 = $urandom;
      if ($urandom_range(0, 3) == 0) op1 = 32'hFFFF_FFFF;
      cycle(got);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(got);
    chk("rand_drained", 64'(q.size()), 64'd0);
    chk("rand_acc", 64'(acc_o), m_acc);
    chk("const_end", 64'(const_o), 64'd32);

    // Narrow instance: ACC 255 three times.
`ifdef OP_ARITH_PIPE_SAT_EN
    e8[0] = 9'd255; e8[1] = 9'd510; e8[2] = 9'd511;
`else
    e8[0] = 9'd255; e8[1] = 9'd510; e8[2] = 9'd253;
`endif
    got8 = 0;
    r8[0] = '0; r8[1] = '0; r8[2] = '0;
    in_v8 = 1'b1; mode8 = 2'd2; a8 = 8'd255;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) in_v8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (out_v8 && got8 < 3) begin
        r8[got8] = res1_8;
        got8++;
      end
    end
    chk("w8_count", 64'(got8), 64'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("w8_res1_%0d", i), 64'(r8[i]), 64'(e8[i]));
    chk("w8_acc", 64'(acc8), 64'(e8[2]));
    chk("w8_const", 64'(const8), 64'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
